// File: rtl/cci_mpf_shim_tag_mgr.sv
// Mdata tag manager for shim-internal requestors: allocates pool slots round-robin,
// builds reserved-bit tags and routes/frees responses back to the owning client.
module cci_mpf_shim_tag_mgr #(
  parameter int N_CLIENTS      = 2,
  parameter int SLOT_BITS      = 4,
  parameter int MDATA_WIDTH    = 16,
  parameter int RESERVED_IDX   = 15,
  parameter int MAX_PER_CLIENT = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CLIENTS-1:0]   alloc_req,
  output logic [N_CLIENTS-1:0]   alloc_gnt,
  output logic [MDATA_WIDTH-1:0] alloc_mdata,
  input  logic                   rsp_valid,
  input  logic [MDATA_WIDTH-1:0] rsp_mdata,
  input  logic                   rsp_last,
  output logic                   rsp_shim,
  output logic [N_CLIENTS-1:0]   rsp_client,
  output logic [SLOT_BITS-1:0]   rsp_slot,
  output logic [SLOT_BITS:0]     n_free,
  output logic                   err
);

  localparam int CLIENT_BITS = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int POOL        = 1 << SLOT_BITS;
  localparam int CNT_W       = SLOT_BITS + 1;
  localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_PER_CLIENT);
  localparam logic [CNT_W-1:0]     POOL_CNT = CNT_W'(POOL);
  localparam logic [CLIENT_BITS:0] N_CL     = (CLIENT_BITS + 1)'(N_CLIENTS);

  // Assertion is immediate; release is delayed two clocks.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [POOL-1:0]        busy_q, busy_d;
  logic [CLIENT_BITS-1:0] owner_q [POOL];
  logic [CLIENT_BITS-1:0] owner_d [POOL];
  logic [CNT_W-1:0]       count_q [N_CLIENTS];
  logic [CNT_W-1:0]       count_d [N_CLIENTS];
  logic [CLIENT_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]       n_free_q, n_free_d;
  logic                   rsp_shim_q, rsp_shim_d;
  logic [N_CLIENTS-1:0]   rsp_client_q, rsp_client_d;
  logic [SLOT_BITS-1:0]   rsp_slot_q, rsp_slot_d;
  logic                   err_q, err_d;

  logic [SLOT_BITS-1:0]   free_slot;
  logic [N_CLIENTS-1:0]   elig;
  logic                   gnt_any;
  logic [CLIENT_BITS-1:0] gnt_idx;

  always_comb begin
    free_slot = '0;
    for (int s = POOL - 1; s >= 0; s--) begin
      if (!busy_q[s]) free_slot = SLOT_BITS'(s);
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      elig[i] = rst_int_n && alloc_req[i] && (count_q[i] < MAX_CNT) && (n_free_q != '0);
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (!gnt_any && elig[(int'(ptr_q) + k) % N_CLIENTS]) begin
        gnt_any = 1'b1;
        gnt_idx = CLIENT_BITS'((int'(ptr_q) + k) % N_CLIENTS);
      end
    end
  end

  always_comb begin
    alloc_gnt   = '0;
    alloc_mdata = '0;
    if (gnt_any) begin
      alloc_gnt                              = N_CLIENTS'(1) << gnt_idx;
      alloc_mdata[RESERVED_IDX]              = 1'b1;
      alloc_mdata[0 +: CLIENT_BITS]          = gnt_idx;
      alloc_mdata[CLIENT_BITS +: SLOT_BITS]  = free_slot;
    end
  end

  logic                   rsp_res, cli_ok, tag_ok, is_shim, free_en, err_set;
  logic [CLIENT_BITS-1:0] rsp_cli;
  logic [SLOT_BITS-1:0]   rsp_sl;
  logic                   unused_mdata;

  assign unused_mdata = ^rsp_mdata;
  assign rsp_res = rsp_valid && rsp_mdata[RESERVED_IDX];
  assign rsp_cli = rsp_mdata[0 +: CLIENT_BITS];
  assign rsp_sl  = rsp_mdata[CLIENT_BITS +: SLOT_BITS];
  assign cli_ok  = {1'b0, rsp_cli} < N_CL;
  assign tag_ok  = cli_ok && busy_q[rsp_sl] && (owner_q[rsp_sl] == rsp_cli);
  assign is_shim = rsp_res && tag_ok;
  assign free_en = is_shim && rsp_last;
  assign err_set = rsp_res && !tag_ok;

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    count_d = count_q;
    if (gnt_any) begin
      busy_d[free_slot]  = 1'b1;
      owner_d[free_slot] = gnt_idx;
    end
    // A granted slot is never the freed one: grants only pick non-busy slots.
    if (free_en) busy_d[rsp_sl] = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt_any && gnt_idx == CLIENT_BITS'(i))
        count_d[i] = count_d[i] + CNT_W'(1);
      if (free_en && owner_q[rsp_sl] == CLIENT_BITS'(i))
        count_d[i] = count_d[i] - CNT_W'(1);
    end

    n_free_d = n_free_q;
    if (gnt_any && !free_en)      n_free_d = n_free_q - CNT_W'(1);
    else if (free_en && !gnt_any) n_free_d = n_free_q + CNT_W'(1);

    ptr_d = gnt_any ? CLIENT_BITS'((int'(gnt_idx) + 1) % N_CLIENTS) : ptr_q;

    rsp_shim_d   = is_shim;
    rsp_client_d = is_shim ? (N_CLIENTS'(1) << rsp_cli) : '0;
    rsp_slot_d   = is_shim ? rsp_sl : rsp_slot_q;
    err_d        = err_q || err_set;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      busy_q       <= '0;
      for (int s = 0; s < POOL; s++) owner_q[s] <= '0;
      for (int i = 0; i < N_CLIENTS; i++) count_q[i] <= '0;
      ptr_q        <= '0;
      n_free_q     <= POOL_CNT;
      rsp_shim_q   <= 1'b0;
      rsp_client_q <= '0;
      rsp_slot_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      n_free_q     <= n_free_d;
      rsp_shim_q   <= rsp_shim_d;
      rsp_client_q <= rsp_client_d;
      rsp_slot_q   <= rsp_slot_d;
      err_q        <= err_d;
    end
  end

  assign rsp_shim   = rsp_shim_q;
  assign rsp_client = rsp_client_q;
  assign rsp_slot   = rsp_slot_q;
  assign n_free     = n_free_q;
  assign err        = err_q;

endmodule
